// File: rtl/aes_pkg.sv
// Shared AES stage definitions: block type, block width and handshake states.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    // Handshake states common to every AES stage block.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_hs_state_e;

    // Lane counter width; a single-lane build still needs a 1-bit counter.
    function automatic int lane_cnt_w(input int nlanes);
        return (nlanes > 1) ? $clog2(nlanes) : 1;
    endfunction

endpackage

// File: rtl/aes_addkey_lane.sv
// Combinational XOR of one LANE_W-bit lane of state and key, picked by lane index.
module aes_addkey_lane
    import aes_pkg::*;
#(
    parameter int LANE_W = 32,
    parameter int CNT_W  = 2
) (
    input  aes_block_t        in_blk,
    input  aes_block_t        key_blk,
    input  logic [CNT_W-1:0]  lane_idx,
    output logic [LANE_W-1:0] lane_xor
);

    localparam int NLANES = AES_BLOCK_W / LANE_W;

    // Lane mux and XOR; lane i occupies bits [i*LANE_W +: LANE_W].
    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (lane_idx == CNT_W'(i)) begin
                lane_xor = in_blk[i*LANE_W +: LANE_W] ^ key_blk[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/aes_addkey.sv
// AES AddRoundKey stage: state XOR round key, one lane per cycle, level start/finish handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the edge that sees start
// BUSY  | one lane XORed per cycle; start low here aborts back to IDLE
// DONE  | result complete; finish held while start stays high
module aes_addkey
    import aes_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  aes_block_t in,
    input  aes_block_t key,
    output logic       finish,
    output aes_block_t addkey
);

    localparam int NLANES = AES_BLOCK_W / LANE_W;
    localparam int CNT_W  = lane_cnt_w(NLANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NLANES - 1);

    aes_hs_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_block_t       in_q, in_d;
    aes_block_t       key_q, key_d;
    aes_block_t       addkey_q, addkey_d;
    logic             finish_q, finish_d;
    logic [LANE_W-1:0] lane_xor;

    aes_addkey_lane #(
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) u_lane (
        .in_blk   (in_q),
        .key_blk  (key_q),
        .lane_idx (cnt_q),
        .lane_xor (lane_xor)
    );

    // Next-state, counter, operand and result logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_d     = in_q;
        key_d    = key_q;
        addkey_d = addkey_q;
        finish_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = in;
                    key_d   = key;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!start) begin
                    // Abort: partial result stays in addkey, finish never rises.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < NLANES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            addkey_d[i*LANE_W +: LANE_W] = lane_xor;
                        end
                    end
                    if (cnt_q == LAST_LANE) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Staying here while start is high is what prevents a retrigger.
                if (start) begin
                    finish_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            in_q     <= '0;
            key_q    <= '0;
            addkey_q <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_q     <= in_d;
            key_q    <= key_d;
            addkey_q <= addkey_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;
    assign addkey = addkey_q;

endmodule

// File: tb/tb_aes_addkey.sv
// Directed bench for aes_addkey with LANE_W=32 (5-cycle latency).
module tb_aes_addkey;
    import aes_pkg::*;

    typedef struct {
        aes_block_t din;
        aes_block_t exp;
    } vec_t;

    localparam aes_block_t KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int         LAT = 5;

    logic       clk;
    logic       rst;
    logic       start;
    aes_block_t in_v;
    aes_block_t key_v;
    logic       finish;
    aes_block_t addkey;

    int n_cmp = 0;
    int n_err = 0;

    aes_addkey #(.LANE_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (in_v),
        .key    (key_v),
        .finish (finish),
        .addkey (addkey)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Raise start with the given operands (called at a negedge) and count
    // edges after the sampling edge until finish is seen; 40 means timeout.
    task automatic run_op(input aes_block_t din, input aes_block_t dk,
                          input bit corrupt, output int lat);
        in_v  = din;
        key_v = dk;
        start = 1'b1;
        @(posedge clk);
        if (corrupt) begin
            @(negedge clk);
            in_v  = '0;
            key_v = '0;
        end
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (finish) break;
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   lat;
        int   seen;

        vecs[0] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h40bfabf406ee4d3042ca6b997a5c5816};
        vecs[1] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h85539f4136ad7e3a35407a244c60c16d};
        vecs[2] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h1bb609508bf236b74e0cd49113c51dd3};
        vecs[3] = '{128'hf69f2445df4f9b17ad2b417be66c3710, 128'hdde13153f7e149b106dc54f3efa3782c};

        rst   = 1'b0;
        start = 1'b0;
        in_v  = '0;
        key_v = '0;
        repeat (3) @(negedge clk);
        chk("reset_finish", 128'(finish), 128'd0);
        chk("reset_addkey", addkey, 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Known-answer vectors.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].din, KEY, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(LAT));
            chk($sformatf("vec%0d_addkey", i), addkey, vecs[i].exp);
            drop_start();
        end

        // Hold start after DONE: finish stays high, operand changes ignored, no restart.
        @(negedge clk);
        run_op(vecs[0].din, KEY, 1'b0, lat);
        chk("hold_latency", 128'(lat), 128'(LAT));
        @(negedge clk);
        in_v = vecs[1].din;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_finish_%0d", c), 128'(finish), 128'd1);
        end
        chk("hold_addkey", addkey, vecs[0].exp);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_finish", 128'(finish), 128'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_finish_%0d", c), 128'(finish), 128'd0);
        end
        @(negedge clk);

        // Operands change one cycle after capture.
        run_op(vecs[0].din, KEY, 1'b1, lat);
        chk("capture_latency", 128'(lat), 128'(LAT));
        chk("capture_addkey", addkey, vecs[0].exp);
        drop_start();

        // Asynchronous reset while BUSY.
        in_v  = vecs[1].din;
        key_v = KEY;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_mid_finish", 128'(finish), 128'd0);
        chk("rst_mid_addkey", addkey, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_op(vecs[2].din, KEY, 1'b0, lat);
        chk("post_rst_latency", 128'(lat), 128'(LAT));
        chk("post_rst_addkey", addkey, vecs[2].exp);
        drop_start();

        // Abort after one lane: low word updated, rest keeps previous result.
        in_v  = vecs[3].din;
        key_v = KEY;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (finish) seen++;
        end
        chk("abort_no_finish", 128'(seen), 128'd0);
        chk("abort_partial", addkey, 128'h1bb609508bf236b74e0cd491efa3782c);
        @(negedge clk);
        run_op(vecs[3].din, KEY, 1'b0, lat);
        chk("post_abort_latency", 128'(lat), 128'(LAT));
        chk("post_abort_addkey", addkey, vecs[3].exp);
        drop_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
